// File: rtl/lsu_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arb_pkg
// Brief    : Shared types and constants for the load/store unit arbiter:
//            FSM state encoding, mem_op codes and the alignment check.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [2:0] MEM_B       = 3'b000;
    localparam logic [2:0] MEM_H       = 3'b001;
    localparam logic [2:0] MEM_W       = 3'b010;
    localparam logic [2:0] MEM_BU      = 3'b100;
    localparam logic [2:0] MEM_HU      = 3'b101;
    localparam logic [2:0] MEM_OP_IDLE = 3'b010;

    // Undefined op codes report as misaligned so they never touch memory.
    function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op)
            MEM_B, MEM_BU: return 1'b1;
            MEM_H, MEM_HU: return ~addr_lo[0];
            MEM_W:         return (addr_lo == 2'b00);
            default:       return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter. Search starts at the
//            requester after i_last_grant and wraps; one-hot grant plus index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    int   w_cand;
    logic w_found;

    // Walk the requesters in priority order and grant the first one found.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_cand      = 0;
        if (i_en) begin
            for (int off = 1; off <= NUM_REQ; off++) begin
                w_cand = int'(i_last_grant) + off;
                if (w_cand >= NUM_REQ) begin
                    w_cand = w_cand - NUM_REQ;
                end
                if (!w_found && i_req[w_cand]) begin
                    w_found          = 1'b1;
                    o_grant[w_cand]  = 1'b1;
                    o_grant_idx      = IDX_W'(w_cand);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Brief    : Shares one load/store unit among NUM_REQ requesters with a
//            round-robin grant and a single outstanding transaction.
//            IDLE (grant) -> ISSUE (one LSU cycle) -> RESP (hold until taken).
// Revision : 1.0 - initial release
// ============================================================================
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 2,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [NUM_REQ*32-1:0] req_addr_i,
    input  logic [NUM_REQ*32-1:0] req_wdata_i,
    input  logic [NUM_REQ*3-1:0]  req_op_i,
    output logic [NUM_REQ-1:0]    rsp_valid_o,
    input  logic [NUM_REQ-1:0]    rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  lsu_st_en_o,
    output logic [31:0]           lsu_addr_o,
    output logic [31:0]           lsu_st_data_o,
    output logic [2:0]            lsu_mem_op_o,
    input  logic [31:0]           lsu_ld_data_i
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_arb_en;
    logic               w_accept;
    logic               w_rsp_done;
    logic [31:0]        w_sel_addr;
    logic [2:0]         w_sel_op;

    logic               r_we;
    logic               r_aligned;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [2:0]         r_op;
    logic [31:0]        r_rdata;
    logic               r_err;

    // Grants are only offered while idle and out of reset.
    assign w_arb_en   = (r_state == IDLE) && !rst_i;
    assign w_accept   = |w_gnt;
    assign w_rsp_done = (r_state == RESP) && rsp_ready_i[r_idx];
    assign w_sel_addr = req_addr_i[32*w_gnt_idx +: 32];
    assign w_sel_op   = req_op_i[3*w_gnt_idx +: 3];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .i_req        (req_valid_i),
        .i_last_grant (r_last_grant),
        .i_en         (w_arb_en),
        .o_grant      (w_gnt),
        .o_grant_idx  (w_gnt_idx)
    );

    assign req_ready_o = w_gnt;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept -> one issue cycle -> hold response until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = ISSUE;
            ISSUE:   w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request register: snapshot the winner so later input changes never reach the LSU.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_idx        <= '0;
            r_we         <= 1'b0;
            r_aligned    <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_op         <= MEM_OP_IDLE;
        end else if (w_accept) begin
            r_last_grant <= w_gnt_idx;
            r_idx        <= w_gnt_idx;
            r_we         <= req_we_i[w_gnt_idx];
            r_aligned    <= is_aligned(w_sel_op, w_sel_addr[1:0]);
            r_addr       <= w_sel_addr;
            r_wdata      <= req_wdata_i[32*w_gnt_idx +: 32];
            r_op         <= w_sel_op;
        end
    end

    // Response register: load data captured at the end of ISSUE, zero for stores/errors.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (r_state == ISSUE) begin
            r_rdata <= (!r_we && r_aligned) ? lsu_ld_data_i : 32'h0;
            r_err   <= ~r_aligned;
        end
    end

    // Output decode: LSU driven only in ISSUE, response presented only in RESP.
    always_comb begin
        lsu_st_en_o   = 1'b0;
        lsu_addr_o    = '0;
        lsu_st_data_o = '0;
        lsu_mem_op_o  = MEM_OP_IDLE;
        rsp_valid_o   = '0;
        rsp_rdata_o   = '0;
        rsp_err_o     = 1'b0;
        if (r_state == ISSUE) begin
            lsu_st_en_o   = r_we && r_aligned && !rst_i;
            lsu_addr_o    = r_addr;
            lsu_st_data_o = r_wdata;
            lsu_mem_op_o  = r_op;
        end
        if (r_state == RESP) begin
            rsp_valid_o[r_idx] = 1'b1;
            rsp_rdata_o        = r_rdata;
            rsp_err_o          = r_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Brief    : Directed self-checking bench for lsu_arbiter with a small
//            byte-addressed memory standing in for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;

    localparam int NUM_REQ = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [63:0] req_addr, req_wdata;
    logic [5:0]  req_op;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        lsu_st_en;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic [2:0]  lsu_mem_op;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_a;

    always #5 clk = ~clk;

    lsu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .req_op_i      (req_op),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .lsu_st_en_o   (lsu_st_en),
        .lsu_addr_o    (lsu_addr),
        .lsu_st_data_o (lsu_st_data),
        .lsu_mem_op_o  (lsu_mem_op),
        .lsu_ld_data_i (lsu_ld_data)
    );

    // LSU model: combinational little-endian read with sign/zero extension.
    always_comb begin
        rd_a = lsu_addr[7:0];
        case (lsu_mem_op)
            3'b000:  lsu_ld_data = {{24{mem[rd_a][7]}}, mem[rd_a]};
            3'b100:  lsu_ld_data = {24'h0, mem[rd_a]};
            3'b001:  lsu_ld_data = {{16{mem[rd_a+8'd1][7]}}, mem[rd_a+8'd1], mem[rd_a]};
            3'b101:  lsu_ld_data = {16'h0, mem[rd_a+8'd1], mem[rd_a]};
            default: lsu_ld_data = {mem[rd_a+8'd3], mem[rd_a+8'd2], mem[rd_a+8'd1], mem[rd_a]};
        endcase
    end

    // LSU model: store commits on the clock edge while enabled.
    always @(posedge clk) begin
        if (lsu_st_en) begin
            case (lsu_mem_op)
                3'b000, 3'b100: mem[lsu_addr[7:0]] <= lsu_st_data[7:0];
                3'b001, 3'b101: begin
                    mem[lsu_addr[7:0]]       <= lsu_st_data[7:0];
                    mem[lsu_addr[7:0]+8'd1]  <= lsu_st_data[15:8];
                end
                default: begin
                    mem[lsu_addr[7:0]]       <= lsu_st_data[7:0];
                    mem[lsu_addr[7:0]+8'd1]  <= lsu_st_data[15:8];
                    mem[lsu_addr[7:0]+8'd2]  <= lsu_st_data[23:16];
                    mem[lsu_addr[7:0]+8'd3]  <= lsu_st_data[31:24];
                end
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from requester k alone, checked cycle by cycle.
    task automatic txn(input string tag, input int k, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] op, input logic [31:0] exp_rdata,
                       input logic exp_err);
        logic [1:0] oh;
        oh = 2'b01 << k;
        req_we[k]            = we;
        req_addr[32*k +: 32] = addr;
        req_wdata[32*k +: 32] = wdata;
        req_op[3*k +: 3]     = op;
        req_valid            = oh;
        #1;
        chk({tag, ".ready"}, 32'(req_ready), 32'(oh));
        step();
        req_valid = 2'b00;
        #1;
        chk({tag, ".iss_addr"}, lsu_addr, addr);
        chk({tag, ".iss_op"}, 32'(lsu_mem_op), 32'(op));
        chk({tag, ".iss_sten"}, 32'(lsu_st_en), 32'(we && !exp_err));
        chk({tag, ".iss_wdata"}, lsu_st_data, wdata);
        chk({tag, ".iss_rspv"}, 32'(rsp_valid), 32'd0);
        step();
        chk({tag, ".rspv"}, 32'(rsp_valid), 32'(oh));
        chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".rsp_lsuop"}, 32'(lsu_mem_op), 32'h2);
        step();
        chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_next;
        int last_acc;

        rst       = 1'b1;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        req_op    = {3'b010, 3'b010};
        rsp_ready = 2'b11;
        step();
        req_valid = 2'b01;
        step();
        chk("rst.ready", 32'(req_ready), 32'd0);
        chk("rst.rspv", 32'(rsp_valid), 32'd0);
        chk("rst.rdata", rsp_rdata, 32'd0);
        chk("rst.err", 32'(rsp_err), 32'd0);
        chk("rst.sten", 32'(lsu_st_en), 32'd0);
        chk("rst.addr", lsu_addr, 32'd0);
        chk("rst.op", 32'(lsu_mem_op), 32'h2);
        req_valid = 2'b00;
        rst       = 1'b0;
        #1;

        // Word store then read-back from requester 0.
        txn("t1.st", 0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        txn("t1.ld", 0, 1'b0, 32'h0000_0010, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);

        // Both requesters loading continuously: grants 1,0,1,0 every third cycle.
        req_we    = 2'b00;
        req_addr  = {32'h0000_0010, 32'h0000_0010};
        req_op    = {3'b010, 3'b010};
        req_valid = 2'b11;
        exp_next  = 1;
        last_acc  = 0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c % 3 == 0) begin
                chk("t2.grant", 32'(req_ready), 32'(2'b01 << exp_next));
                last_acc = exp_next;
                exp_next = 1 - exp_next;
            end else begin
                chk("t2.nogrant", 32'(req_ready), 32'd0);
            end
            if (c % 3 == 2) begin
                chk("t2.rspv", 32'(rsp_valid), 32'(2'b01 << last_acc));
                chk("t2.rdata", rsp_rdata, 32'hDEAD_BEEF);
            end
            step();
        end
        req_valid = 2'b00;
        #1;

        // Misaligned accesses: error response, no LSU write.
        txn("t3.st400", 0, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0);
        txn("t3.ldh", 1, 1'b0, 32'h0000_0403, 32'h0, 3'b001, 32'h0, 1'b1);
        txn("t3.stw", 1, 1'b1, 32'h0000_0402, 32'h1111_2222, 3'b010, 32'h0, 1'b1);
        txn("t3.rb", 0, 1'b0, 32'h0000_0400, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0);

        // Response backpressure for five cycles; non-owner ready is ignored.
        req_we    = 2'b00;
        req_addr  = {32'h0000_0010, 32'h0000_0010};
        req_op    = {3'b010, 3'b010};
        rsp_ready = 2'b10;
        req_valid = 2'b01;
        #1;
        chk("t4.ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        step();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4.hold_rspv", 32'(rsp_valid), 32'h1);
            chk("t4.hold_rdata", rsp_rdata, 32'hDEAD_BEEF);
            chk("t4.hold_ready", 32'(req_ready), 32'd0);
            chk("t4.hold_sten", 32'(lsu_st_en), 32'd0);
            chk("t4.hold_addr", lsu_addr, 32'd0);
            chk("t4.hold_op", 32'(lsu_mem_op), 32'h2);
            step();
        end
        rsp_ready = 2'b11;
        #1;
        chk("t4.cmpl_rspv", 32'(rsp_valid), 32'h1);
        chk("t4.cmpl_ready", 32'(req_ready), 32'd0);
        step();
        chk("t4.after_rspv", 32'(rsp_valid), 32'd0);
        chk("t4.after_grant", 32'(req_ready), 32'h2);
        req_valid = 2'b00;
        #1;

        // Reset during the ISSUE cycle of a store: no commit, state discarded.
        txn("t5.pre", 0, 1'b1, 32'h0000_0020, 32'hAAAA_5555, 3'b010, 32'h0, 1'b0);
        req_we[0]       = 1'b1;
        req_addr[31:0]  = 32'h0000_0020;
        req_wdata[31:0] = 32'h1234_5678;
        req_op[2:0]     = 3'b010;
        req_valid       = 2'b01;
        #1;
        chk("t5.ready", 32'(req_ready), 32'h1);
        step();
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("t5.iss_sten", 32'(lsu_st_en), 32'd0);
        chk("t5.iss_addr", lsu_addr, 32'h0000_0020);
        step();
        chk("t5.rst_rspv", 32'(rsp_valid), 32'd0);
        chk("t5.rst_ready", 32'(req_ready), 32'd0);
        chk("t5.rst_rdata", rsp_rdata, 32'd0);
        chk("t5.rst_err", 32'(rsp_err), 32'd0);
        chk("t5.rst_addr", lsu_addr, 32'd0);
        chk("t5.rst_wdata", lsu_st_data, 32'd0);
        chk("t5.rst_op", 32'(lsu_mem_op), 32'h2);
        rst = 1'b0;
        #1;
        txn("t5.rb", 0, 1'b0, 32'h0000_0020, 32'h0, 3'b010, 32'hAAAA_5555, 1'b0);

        // Sub-word loads with zero and sign extension.
        txn("t6.st", 0, 1'b1, 32'h0000_0010, 32'h0000_8000, 3'b010, 32'h0, 1'b0);
        txn("t6.bu", 1, 1'b0, 32'h0000_0011, 32'h0, 3'b100, 32'h0000_0080, 1'b0);
        txn("t6.b", 0, 1'b0, 32'h0000_0011, 32'h0, 3'b000, 32'hFFFF_FF80, 1'b0);
        txn("t6.hu", 1, 1'b0, 32'h0000_0010, 32'h0, 3'b101, 32'h0000_8000, 1'b0);
        txn("t6.h", 0, 1'b0, 32'h0000_0010, 32'h0, 3'b001, 32'hFFFF_8000, 1'b0);
        txn("t6.bad_op", 1, 1'b0, 32'h0000_0010, 32'h0, 3'b011, 32'h0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
